timer_tick_ctrl: RTL and testbench

Upstream control stage for the countdown display timer. Converts raw DE2 push-button inputs into start, pause and resume commands. Divides the system clock into a one-cycle one_second_pulse tick and a reload strobe, which drive the countdown counter. Consumes game_finished from the countdown stage and stops ticking once time expires.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/timer_tick_ctrl_if.sv | 25 ++
 rtl/key_debounce.sv | 75 +++++++
 rtl/timer_tick_ctrl.sv | 125 ++++++++++++
 tb/tb_timer_tick_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the tick controller and the countdown stage.
//   state_e             : controller state encoding
//   DEFAULT_*           : default clocking and debounce settings
//   TIMER_START_SECONDS : value the countdown reloads to on timer_load
//   cnt_width()         : counter width for a terminal count, at least 1 bit
package timer_pkg;

   localparam int DEFAULT_CLK_FREQ_HZ     = 50_000_000;
   localparam int DEFAULT_TICK_HZ         = 1;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
   localparam int TIMER_START_SECONDS     = 30;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUNNING,
      ST_PAUSED,
      ST_DONE
   } state_e;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/timer_tick_ctrl_if.sv
// Key / status bundle between the push-button front end and the countdown.
//   master : drives raw keys and game_finished, observes status and strobes
//   slave  : the tick controller
interface timer_tick_ctrl_if;

   logic key_start_n;
   logic key_pause_n;
   logic game_finished;
   logic one_second_pulse;
   logic timer_load;
   logic running;
   logic paused;
   logic done;

   modport master (
      output key_start_n, key_pause_n, game_finished,
      input  one_second_pulse, timer_load, running, paused, done
   );

   modport slave (
      input  key_start_n, key_pause_n, game_finished,
      output one_second_pulse, timer_load, running, paused, done
   );

endinterface

// File: rtl/key_debounce.sv
// Push-button front end: 2-FF synchronizer, debounce counter, press strobe.
//   clk, rst_n : system clock, async active-low reset
//   key_n      : raw active-low key
//   press      : one-cycle strobe when a debounced press is accepted
module key_debounce
   import timer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic [1:0]    fill_q;
   logic          armed_q, armed_d;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;
   logic          mismatch;

   // Until armed, the counter instead qualifies a stable release, so a key
   // held through reset never turns into a press. fill_q ignores the reset
   // values still sitting in the synchronizer.
   always_comb begin
      mismatch = 1'b0;
      if (fill_q[1]) begin
         mismatch = armed_q ? (sync2_q != level_q) : sync2_q;
      end
      cnt_d   = '0;
      level_d = level_q;
      armed_d = armed_q;
      press_d = 1'b0;
      if (mismatch) begin
         if (cnt_q == CNT_LAST) begin
            if (armed_q) begin
               level_d = sync2_q;
               press_d = ~sync2_q;
            end else begin
               armed_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         fill_q  <= 2'b00;
         armed_q <= 1'b0;
         level_q <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
         fill_q  <= {fill_q[0], 1'b1};
         armed_q <= armed_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/timer_tick_ctrl.sv
// Tick controller: turns debounced keys into start/pause/resume, divides
// clk into one_second_pulse, and issues timer_load on (re)start.
//   clk, rst_n : system clock, async active-low reset
//   bus        : keys and game_finished in; pulse, load and status out
//
// state   | meaning
// IDLE    | waiting for start after reset
// LOAD    | one cycle, timer_load high, prescaler restarted
// RUNNING | prescaler counting, one_second_pulse on wrap
// PAUSED  | prescaler frozen, waiting for resume or restart
// DONE    | countdown expired, waiting for restart
module timer_tick_ctrl
   import timer_pkg::*;
#(
   parameter int CLK_FREQ_HZ     = DEFAULT_CLK_FREQ_HZ,
   parameter int TICK_HZ         = DEFAULT_TICK_HZ,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   timer_tick_ctrl_if.slave  bus
);

   localparam int            DIV        = CLK_FREQ_HZ / TICK_HZ;
   localparam int            PW         = $clog2(DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   logic          start_p, pause_p;
   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          pulse_q, pulse_d;
   logic          load_q, load_d;
   logic          running_q, running_d;
   logic          paused_q, paused_d;
   logic          done_q, done_d;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (bus.key_start_n),
      .press (start_p)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_pause (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (bus.key_pause_n),
      .press (pause_p)
   );

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      pulse_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_p) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            // The LOAD cycle is the first count of the period, so the first
            // tick lands DIV cycles after LOAD.
            state_d = ST_RUNNING;
            presc_d = PW'(1);
         end
         ST_RUNNING: begin
            if (start_p) begin
               state_d = ST_LOAD;
            end else if (bus.game_finished) begin
               state_d = ST_DONE;
               presc_d = '0;
            end else if (pause_p) begin
               state_d = ST_PAUSED;
            end else if (presc_q == PRESC_LAST) begin
               presc_d = '0;
               pulse_d = 1'b1;
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         ST_PAUSED: begin
            if (start_p)      state_d = ST_LOAD;
            else if (pause_p) state_d = ST_RUNNING;
         end
         ST_DONE: begin
            if (start_p) state_d = ST_LOAD;
         end
         default: begin
            state_d = ST_IDLE;
            presc_d = '0;
         end
      endcase
      if (state_d == ST_LOAD) presc_d = '0;
      load_d    = (state_d == ST_LOAD);
      running_d = (state_d == ST_RUNNING);
      paused_d  = (state_d == ST_PAUSED);
      done_d    = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         presc_q   <= '0;
         pulse_q   <= 1'b0;
         load_q    <= 1'b0;
         running_q <= 1'b0;
         paused_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         pulse_q   <= pulse_d;
         load_q    <= load_d;
         running_q <= running_d;
         paused_q  <= paused_d;
         done_q    <= done_d;
      end
   end

   assign bus.one_second_pulse = pulse_q;
   assign bus.timer_load       = load_q;
   assign bus.running          = running_q;
   assign bus.paused           = paused_q;
   assign bus.done             = done_q;

endmodule

// File: tb/tb_timer_tick_ctrl.sv
module tb_timer_tick_ctrl;
   import timer_pkg::*;

   localparam int CLK_HZ = 10;
   localparam int TICK   = 1;
   localparam int DEB    = 4;
   localparam int DIV    = CLK_HZ / TICK;

   localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   timer_tick_ctrl_if bus ();

   timer_tick_ctrl #(
      .CLK_FREQ_HZ     (CLK_HZ),
      .TICK_HZ         (TICK),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Keys: the pin is seen two edges late; a level change is accepted after
   // DEB consecutive differing samples. After reset a key must first be seen
   // released for DEB samples before any press counts.
   // FSM: m_rem = cycles left until the next tick.
   int  m_st  = M_IDLE;
   int  m_rem = DIV;
   bit  e_load = 0, e_pulse = 0, e_run = 0, e_pause = 0, e_done = 0;
   bit  [2:0] hist [2];
   int  run    [2];
   bit  armed  [2];
   bit  lvl    [2];
   bit  prs    [2];
   int  k_edges = 0;
   bit  start_c, pause_c, gf_c, s_c, pin_c;

   initial begin
      for (int i = 0; i < 2; i++) begin
         hist[i] = 3'b111; run[i] = 0; armed[i] = 0; lvl[i] = 1; prs[i] = 0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st = M_IDLE; m_rem = DIV; k_edges = 0;
         e_load = 0; e_pulse = 0; e_run = 0; e_pause = 0; e_done = 0;
         for (int i = 0; i < 2; i++) begin
            hist[i] = 3'b111; run[i] = 0; armed[i] = 0; lvl[i] = 1; prs[i] = 0;
         end
      end else begin
         start_c = prs[0];
         pause_c = prs[1];
         gf_c    = bus.game_finished;
         e_pulse = 0;
         case (m_st)
            M_IDLE:  if (start_c) m_st = M_LOAD;
            M_LOAD:  begin m_st = M_RUN; m_rem = m_rem - 1; end
            M_RUN: begin
               if (start_c)      m_st = M_LOAD;
               else if (gf_c)    m_st = M_DONE;
               else if (pause_c) m_st = M_PAUSE;
               else begin
                  m_rem = m_rem - 1;
                  if (m_rem == 0) begin e_pulse = 1; m_rem = DIV; end
               end
            end
            M_PAUSE: begin
               if (start_c)      m_st = M_LOAD;
               else if (pause_c) m_st = M_RUN;
            end
            default: if (start_c) m_st = M_LOAD;
         endcase
         if (m_st == M_LOAD) m_rem = DIV;
         e_load  = (m_st == M_LOAD);
         e_run   = (m_st == M_RUN);
         e_pause = (m_st == M_PAUSE);
         e_done  = (m_st == M_DONE);

         k_edges++;
         for (int i = 0; i < 2; i++) begin
            pin_c   = (i == 0) ? bus.key_start_n : bus.key_pause_n;
            hist[i] = {hist[i][1:0], pin_c};
            prs[i]  = 0;
            if (k_edges >= 3) begin
               s_c = hist[i][2];
               if (!armed[i]) begin
                  run[i] = s_c ? run[i] + 1 : 0;
                  if (run[i] == DEB) begin armed[i] = 1; run[i] = 0; end
               end else begin
                  run[i] = (s_c != lvl[i]) ? run[i] + 1 : 0;
                  if (run[i] == DEB) begin
                     lvl[i] = s_c; prs[i] = !s_c; run[i] = 0;
                  end
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare + event log ----------------
   int  load_q[$], pulse_q[$], rise_q[$];
   bit  run_prev = 0;

   always @(negedge clk) begin
      chk("timer_load",       bus.timer_load,       e_load);
      chk("one_second_pulse", bus.one_second_pulse, e_pulse);
      chk("running",          bus.running,          e_run);
      chk("paused",           bus.paused,           e_pause);
      chk("done",             bus.done,             e_done);
      if (bus.timer_load)       load_q.push_back(cyc);
      if (bus.one_second_pulse) pulse_q.push_back(cyc);
      if (bus.running && !run_prev) rise_q.push_back(cyc);
      run_prev = bus.running;
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_log();
      load_q.delete(); pulse_q.delete(); rise_q.delete();
   endtask

   task automatic wait_pulse(input string name);
      bit found = 0;
      for (int i = 0; i < 3 * DIV && !found; i++) begin
         @(negedge clk); #1;
         if (bus.one_second_pulse === 1'b1) found = 1;
      end
      if (!found) chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic press_key(input bit is_start, input int low_cycles);
      if (is_start) bus.key_start_n = 1'b0; else bus.key_pause_n = 1'b0;
      cycles(low_cycles);
      if (is_start) bus.key_start_n = 1'b1; else bus.key_pause_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.key_start_n   = 1'b1;
      bus.key_pause_n   = 1'b1;
      bus.game_finished = 1'b0;
      rst_n = 1'b0;
      cycles(5);
      rst_n = 1'b1;

      // 1: idle after reset
      clear_log();
      cycles(50);
      chk("t1_loads",   load_q.size(),  0);
      chk("t1_pulses",  pulse_q.size(), 0);
      chk("t1_running", bus.running,    0);
      chk("t1_state",   dut.state_q,    ST_IDLE);

      // 3: bounce shorter than the debounce window
      bus.key_start_n = 1'b0; cycles(3);
      bus.key_start_n = 1'b1; cycles(3);
      bus.key_start_n = 1'b0; cycles(2);
      bus.key_start_n = 1'b1; cycles(20);
      chk("t3_loads", load_q.size(), 0);
      chk("t3_state", dut.state_q,   ST_IDLE);

      // 2: start held 12 cycles
      clear_log();
      press_key(1, 12);
      cycles(30);
      chk("t2_load_count",  load_q.size(),  1);
      chk("t2_pulse_count", pulse_q.size(), 3);
      if (load_q.size() == 1 && pulse_q.size() == 3 && rise_q.size() == 1) begin
         chk("t2_run_after_load", rise_q[0]  - load_q[0], 1);
         chk("t2_pulse1",         pulse_q[0] - load_q[0], 10);
         chk("t2_pulse2",         pulse_q[1] - load_q[0], 20);
         chk("t2_pulse3",         pulse_q[2] - load_q[0], 30);
      end else chk("t2_log_shape", 0, 1);

      // 4: pause accepted with the prescaler at 4, then resume
      wait_pulse("t4_sync");
      cycles(8);
      press_key(0, 6);
      cycles(2);
      chk("t4_paused", bus.paused,  1);
      chk("t4_presc",  dut.presc_q, 4);
      clear_log();
      cycles(30);
      chk("t4_no_pulse",    pulse_q.size(), 0);
      chk("t4_presc_held",  dut.presc_q,    4);
      clear_log();
      press_key(0, 6);
      cycles(20);
      if (rise_q.size() == 1 && pulse_q.size() >= 2) begin
         chk("t4_resume_gap",  pulse_q[0] - rise_q[0], 6);
         chk("t4_resume_gap2", pulse_q[1] - rise_q[0], 16);
      end else chk("t4_log_shape", 0, 1);

      // 5: game_finished while prescaler is 9
      wait_pulse("t5_sync");
      cycles(9);
      bus.game_finished = 1'b1;
      cycles(1);
      chk("t5_done",     bus.done,             1);
      chk("t5_no_pulse", bus.one_second_pulse, 0);
      clear_log();
      cycles(40);
      chk("t5_quiet", pulse_q.size(), 0);
      bus.game_finished = 1'b0;
      clear_log();
      press_key(1, 6);
      cycles(30);
      chk("t5_load_count", load_q.size(), 1);
      if (load_q.size() == 1 && pulse_q.size() >= 2) begin
         chk("t5_pulse1", pulse_q[0] - load_q[0], 10);
         chk("t5_pulse2", pulse_q[1] - load_q[0], 20);
      end else chk("t5_log_shape", 0, 1);

      // 6: reset pulse at prescaler 9 with start held through it
      wait_pulse("t6_sync");
      cycles(9);
      clear_log();
      rst_n = 1'b0;
      bus.key_start_n = 1'b0;
      #1;
      chk("t6_running_clr", bus.running,          0);
      chk("t6_pulse_clr",   bus.one_second_pulse, 0);
      cycles(1);
      rst_n = 1'b1;
      chk("t6_no_pulse", pulse_q.size(), 0);
      cycles(30);
      chk("t6_held_no_load", load_q.size(), 0);
      chk("t6_state",        dut.state_q,   ST_IDLE);
      bus.key_start_n = 1'b1;
      cycles(8);
      press_key(1, 6);
      cycles(10);
      chk("t6_repress_load", load_q.size(), 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
